// File: rtl/fcvt_d2i_post_pkg.sv
// Shared types and constants for the double-to-integer post-processing stage.
package fcvt_d2i_post_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [63:0] L_S_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] L_S_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] W_S_MAX = 64'h0000_0000_7FFF_FFFF;
  localparam logic [63:0] W_S_MIN = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] U_MAX   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] U_MIN   = 64'h0;

  localparam logic [10:0] EXP_ONE   = 11'h3FF;
  localparam logic [10:0] EXP_W_S   = 11'h41D;
  localparam logic [10:0] EXP_W_U   = 11'h41E;
  localparam logic [10:0] EXP_L_S   = 11'h43D;
  localparam logic [10:0] EXP_L_U   = 11'h43E;
  localparam logic [10:0] EXP_FRAC0 = 11'h433;  // exponent at which no fraction bits remain
  localparam logic [10:0] EXP_MAX   = 11'h7FF;

  typedef struct packed {
    state_t      state;
    logic        sign;
    logic [10:0] exp;
    logic [51:0] frac;
    logic        sgn;
    logic        w32;
    logic [63:0] res;
    logic [4:0]  fflags;
    logic        valid;
  } regs_t;

  localparam regs_t REGS_RST = '{ST_IDLE, 1'b0, 11'd0, 52'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0};

endpackage

// File: rtl/fcvt_d2i_post_if.sv
// Issue, converter-result and output handshake bundle of fcvt_d2i_post.
interface fcvt_d2i_post_if;
  logic        i_ena;
  logic        i_signed;
  logic        i_w32;
  logic [63:0] i_a;
  logic [63:0] i_d2l_res;
  logic        i_d2l_overflow;
  logic        i_d2l_underflow;
  logic        i_d2l_valid;
  logic        i_ready;
  logic [63:0] o_res;
  logic [4:0]  o_fflags;
  logic        o_valid;
  logic        o_busy;

  modport master (output i_ena, i_signed, i_w32, i_a, i_d2l_res, i_d2l_overflow,
                         i_d2l_underflow, i_d2l_valid, i_ready,
                  input  o_res, o_fflags, o_valid, o_busy);
  modport slave  (input  i_ena, i_signed, i_w32, i_a, i_d2l_res, i_d2l_overflow,
                         i_d2l_underflow, i_d2l_valid, i_ready,
                  output o_res, o_fflags, o_valid, o_busy);
endinterface

// File: rtl/fcvt_d2i_post_classify.sv
// Combinational operand classification for the d2i post stage.
// Inexact detection exists only when FCVT_D2I_NX_EN is defined.
module fcvt_d2i_classify
  import fcvt_d2i_post_pkg::*;
(
  input  logic        sign,
  input  logic [10:0] exp,
  input  logic [51:0] frac,
  input  logic        is_signed,
  input  logic        w32,
  output logic        nan,
  output logic        inf,
  output logic        zero,
  output logic        lt_one,
  output logic        out_of_range,
  output logic        exact_min,
  output logic        inexact
);
  logic [10:0] lim;

  always_comb begin
    case ({w32, is_signed})
      2'b00:   lim = EXP_L_U;
      2'b01:   lim = EXP_L_S;
      2'b10:   lim = EXP_W_U;
      default: lim = EXP_W_S;
    endcase
  end

  assign nan          = (exp == EXP_MAX) && (frac != '0);
  assign inf          = (exp == EXP_MAX) && (frac == '0);
  assign zero         = (exp == '0) && (frac == '0);
  assign lt_one       = exp < EXP_ONE;
  assign out_of_range = exp > lim;
  // -2^63 / -2^31 sit one exponent above the signed limit but are representable
  assign exact_min    = is_signed && sign && (frac == '0) && (exp == (w32 ? EXP_W_U : EXP_L_U));

`ifdef FCVT_D2I_NX_EN
  logic [10:0] sh;
  logic [51:0] fmask;
  always_comb begin
    sh    = EXP_FRAC0 - exp;
    fmask = ~({52{1'b1}} << sh);
  end
  assign inexact = !zero && (lt_one || ((exp < EXP_FRAC0) && |(frac & fmask)));
`else
  assign inexact = 1'b0;
`endif

endmodule

// File: rtl/fcvt_d2i_post.sv
// Double-to-integer post stage: RISC-V saturation, fflags and output handshake.
// Optional NX flag generation via FCVT_D2I_NX_EN.
module fcvt_d2i_post
  import fcvt_d2i_post_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_nrst,
  fcvt_d2i_post_if.slave  bus
);
  regs_t r;
  logic c_nan, c_inf, c_zero, c_lt_one, c_oor, c_exact_min, c_inexact;
  logic [63:0] max_v, min_v, nxt_res;
  logic nv, nx;

  fcvt_d2i_classify u_cls (
    .sign(r.sign), .exp(r.exp), .frac(r.frac), .is_signed(r.sgn), .w32(r.w32),
    .nan(c_nan), .inf(c_inf), .zero(c_zero), .lt_one(c_lt_one),
    .out_of_range(c_oor), .exact_min(c_exact_min), .inexact(c_inexact)
  );

  always_comb begin
    max_v   = r.sgn ? (r.w32 ? W_S_MAX : L_S_MAX) : U_MAX;
    min_v   = r.w32 ? W_S_MIN : L_S_MIN;
    nxt_res = '0;
    nv      = 1'b0;
    nx      = 1'b0;
    if (c_nan || (!r.sign && (c_inf || c_oor))) begin
      nxt_res = max_v;
      nv      = 1'b1;
    end else if (c_exact_min) begin
      nxt_res = min_v;
    end else if (r.sign && (c_inf || c_oor)) begin
      nxt_res = r.sgn ? min_v : U_MIN;
      nv      = 1'b1;
    end else if (!r.sgn && r.sign && !c_lt_one) begin
      nv = 1'b1;
    end else if (c_zero || c_lt_one || bus.i_d2l_underflow) begin
      nx = c_inexact;
    end else begin
      nxt_res = r.w32 ? {{32{bus.i_d2l_res[31]}}, bus.i_d2l_res[31:0]} : bus.i_d2l_res;
      nx      = c_inexact;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= REGS_RST;
    end else begin
      case (r.state)
        ST_IDLE: if (bus.i_ena) begin
          r.sign  <= bus.i_a[63];
          r.exp   <= bus.i_a[62:52];
          r.frac  <= bus.i_a[51:0];
          r.sgn   <= bus.i_signed;
          r.w32   <= bus.i_w32;
          r.state <= ST_WAIT;
        end
        ST_WAIT: if (bus.i_d2l_valid) begin
          r.res    <= nxt_res;
          r.fflags <= {nv, 3'b000, nx};
          r.valid  <= 1'b1;
          r.state  <= ST_DONE;
        end
        ST_DONE: if (bus.i_ready) begin
          r.valid <= 1'b0;
          r.state <= ST_IDLE;
        end
        default: r.state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_res    = r.res;
  assign bus.o_fflags = r.fflags;
  assign bus.o_valid  = r.valid;
  assign bus.o_busy   = (r.state != ST_IDLE);

endmodule

// File: tb/tb_fcvt_d2i_post.sv
// Directed bench for fcvt_d2i_post: vector table plus stall and reset sequences.
module tb_fcvt_d2i_post;
  logic i_clk = 1'b0;
  logic i_nrst = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef FCVT_D2I_NX_EN
  localparam logic NXB = 1'b1;
`else
  localparam logic NXB = 1'b0;
`endif

  fcvt_d2i_post_if bus ();
  fcvt_d2i_post dut (.i_clk(i_clk), .i_nrst(i_nrst), .bus(bus));

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic        sgn;
    logic        w32;
    logic [63:0] cres;
    logic        ovf;
    logic        unf;
    logic [63:0] eres;
    logic        env;
    logic        enx;
  } vec_t;

  vec_t v[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_ena = 0; bus.i_signed = 0; bus.i_w32 = 0; bus.i_a = '0;
    bus.i_d2l_res = '0; bus.i_d2l_overflow = 0; bus.i_d2l_underflow = 0;
    bus.i_d2l_valid = 0; bus.i_ready = 0;
  endtask

  // issue, converter result 3 cycles later; leaves the block in DONE
  task automatic issue(input vec_t t);
    bus.i_ena = 1; bus.i_a = t.a; bus.i_signed = t.sgn; bus.i_w32 = t.w32;
    tick();
    bus.i_ena = 0; bus.i_a = '0;
    chk({t.name, " busy_wait"}, {63'd0, bus.o_busy}, 64'd1);
    tick();
    tick();
    bus.i_d2l_valid = 1; bus.i_d2l_res = t.cres;
    bus.i_d2l_overflow = t.ovf; bus.i_d2l_underflow = t.unf;
    chk({t.name, " valid_early"}, {63'd0, bus.o_valid}, 64'd0);
    tick();
    bus.i_d2l_valid = 0; bus.i_d2l_res = '0;
    bus.i_d2l_overflow = 0; bus.i_d2l_underflow = 0;
  endtask

  task automatic check_out(input vec_t t);
    chk({t.name, " valid"}, {63'd0, bus.o_valid}, 64'd1);
    chk({t.name, " res"}, bus.o_res, t.eres);
    chk({t.name, " fflags"}, {59'd0, bus.o_fflags}, {59'd0, t.env, 3'b000, t.enx & NXB});
  endtask

  initial begin
    vec_t s;
    idle_inputs();
    v[0]  = '{"one_p5",     64'h3FF8000000000000, 1, 0, 64'd1,                 0, 0, 64'd1,                 0, 1};
    v[1]  = '{"nan_sw",     64'h7FF8000000000000, 1, 1, 64'h0000000080000000,  1, 0, 64'h000000007FFFFFFF,  1, 0};
    v[2]  = '{"min_sl",     64'hC3E0000000000000, 1, 0, 64'h7FFFFFFFFFFFFFFF,  1, 0, 64'h8000000000000000,  0, 0};
    v[3]  = '{"neg3_ul",    64'hC008000000000000, 0, 0, 64'hFFFFFFFFFFFFFFFD,  0, 0, 64'd0,                 1, 0};
    v[4]  = '{"negp5_ul",   64'hBFE0000000000000, 0, 0, 64'd0,                 0, 1, 64'd0,                 0, 1};
    v[5]  = '{"p2_32_uw",   64'h41F0000000000000, 0, 1, 64'd0,                 1, 0, 64'hFFFFFFFFFFFFFFFF,  1, 0};
    v[6]  = '{"negp1_5_sw", 64'hBFF8000000000000, 1, 1, 64'h00000000FFFFFFFF,  0, 0, 64'hFFFFFFFFFFFFFFFF,  0, 1};
    v[7]  = '{"pinf_ul",    64'h7FF0000000000000, 0, 0, 64'd0,                 1, 0, 64'hFFFFFFFFFFFFFFFF,  1, 0};
    v[8]  = '{"ninf_sl",    64'hFFF0000000000000, 1, 0, 64'd0,                 1, 0, 64'h8000000000000000,  1, 0};
    v[9]  = '{"ninf_sw",    64'hFFF0000000000000, 1, 1, 64'd0,                 1, 0, 64'hFFFFFFFF80000000,  1, 0};
    v[10] = '{"min_sw",     64'hC1E0000000000000, 1, 1, 64'h0000000080000000,  0, 0, 64'hFFFFFFFF80000000,  0, 0};
    v[11] = '{"p2_31_sw",   64'h41E0000000000000, 1, 1, 64'h0000000080000000,  1, 0, 64'h000000007FFFFFFF,  1, 0};
    v[12] = '{"p2_31_uw",   64'h41E0000000000000, 0, 1, 64'h0000000080000000,  0, 0, 64'hFFFFFFFF80000000,  0, 0};
    v[13] = '{"zero_sl",    64'h0000000000000000, 1, 0, 64'd0,                 0, 1, 64'd0,                 0, 0};
    v[14] = '{"nzero_ul",   64'h8000000000000000, 0, 0, 64'd0,                 0, 1, 64'd0,                 0, 0};
    v[15] = '{"three_ul",   64'h4008000000000000, 0, 0, 64'd3,                 0, 0, 64'd3,                 0, 0};
    v[16] = '{"p2_63_ul",   64'h43E0000000000000, 0, 0, 64'h8000000000000000,  0, 0, 64'h8000000000000000,  0, 0};
    v[17] = '{"p2_63_sl",   64'h43E0000000000000, 1, 0, 64'h8000000000000000,  1, 0, 64'h7FFFFFFFFFFFFFFF,  1, 0};

    #12;
    chk("rst_res", bus.o_res, 64'd0);
    chk("rst_flags", {59'd0, bus.o_fflags}, 64'd0);
    chk("rst_valid", {63'd0, bus.o_valid}, 64'd0);
    chk("rst_busy", {63'd0, bus.o_busy}, 64'd0);
    i_nrst = 1;
    tick();

    for (int i = 0; i < 18; i++) begin
      issue(v[i]);
      check_out(v[i]);
      bus.i_ready = 1;
      tick();
      bus.i_ready = 0;
      chk({v[i].name, " valid_drop"}, {63'd0, bus.o_valid}, 64'd0);
      chk({v[i].name, " busy_drop"}, {63'd0, bus.o_busy}, 64'd0);
    end

    // stall in DONE: output held, stray issue and converter strobes ignored
    s = v[0];
    s.name = "stall";
    issue(s);
    for (int k = 0; k < 5; k++) begin
      bus.i_ena = (k == 1); bus.i_a = 64'h7FF8000000000000; bus.i_signed = 1;
      bus.i_d2l_valid = (k == 3); bus.i_d2l_res = 64'h55;
      tick();
      check_out(s);
      chk("stall busy", {63'd0, bus.o_busy}, 64'd1);
    end
    bus.i_d2l_valid = 0;
    bus.i_ena = 1; bus.i_ready = 1;
    tick();
    bus.i_ena = 0; bus.i_ready = 0;
    chk("stall release valid", {63'd0, bus.o_valid}, 64'd0);
    chk("stall ena_same_cycle busy", {63'd0, bus.o_busy}, 64'd0);
    tick();
    chk("stall idle busy", {63'd0, bus.o_busy}, 64'd0);

    // reset while waiting on the converter
    bus.i_ena = 1; bus.i_a = 64'h3FF8000000000000; bus.i_signed = 1; bus.i_w32 = 0;
    tick();
    bus.i_ena = 0;
    chk("wrst busy_before", {63'd0, bus.o_busy}, 64'd1);
    #2 i_nrst = 0;
    #1;
    chk("wrst busy", {63'd0, bus.o_busy}, 64'd0);
    chk("wrst res", bus.o_res, 64'd0);
    chk("wrst flags", {59'd0, bus.o_fflags}, 64'd0);
    chk("wrst valid", {63'd0, bus.o_valid}, 64'd0);
    tick();
    i_nrst = 1;
    tick();
    bus.i_d2l_valid = 1; bus.i_d2l_res = 64'd1;
    tick();
    bus.i_d2l_valid = 0;
    chk("late d2l valid", {63'd0, bus.o_valid}, 64'd0);
    chk("late d2l busy", {63'd0, bus.o_busy}, 64'd0);
    chk("late d2l res", bus.o_res, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fcvt_d2i_post.md
# fcvt_d2i_post

Post-processing stage directly downstream of the double-to-integer converter in the FPU_D pipeline. It captures the operand and mode when the converter is issued, then waits for the converter's result. It substitutes RISC-V-conformant saturated values for NaN, infinity, out-of-range and boundary inputs, and computes the fflags. The result is held in an output register under a valid/ready handshake with the FPU result mux.

## Interface
- async_reset, 1'b1: reset style; this block is always instantiated with asynchronous reset.
- i_clk  in  1  CPU clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_ena  in  1  issue strobe, same cycle as the converter's i_ena
- i_signed  in  1  1 = FCVT.W/L, 0 = FCVT.WU/LU
- i_w32  in  1  1 = 32-bit result, sign-extended to 64
- i_a  in  64  IEEE-754 double operand
- i_d2l_res  in  64  converter result
- i_d2l_overflow  in  1  converter overflow (informational only)
- i_d2l_underflow  in  1  converter |x|<1 indication
- i_d2l_valid  in  1  converter result strobe
- i_ready  in  1  consumer accepts o_res
- o_res  out  64  final integer result
- o_fflags  out  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0
- o_valid  out  1  result available; held until accepted
- o_busy  out  1  high in WAIT and DONE

## Operation
- FSM states are IDLE, WAIT and DONE.
- IDLE: on i_ena, capture sign, exp[10:0], frac[51:0], i_signed and i_w32, then go to WAIT.
- WAIT: on i_d2l_valid, register the final o_res and o_fflags, set o_valid, then go to DONE.
- DONE: on i_ready, clear o_valid and go to IDLE.
- i_ena in WAIT or DONE is ignored. i_d2l_valid in IDLE or DONE is ignored.
- Classification uses only the captured operand, never the converter flags:
  - NaN: exp=0x7FF and frac≠0.
  - Inf: exp=0x7FF and frac=0.
  - Zero: exp=0 and frac=0.
- In-range limits:
  - signed L: exp≤0x43D.
  - unsigned L (positive only): exp≤0x43E.
  - signed W: exp≤0x41D.
  - unsigned W (positive only): exp≤0x41E.
- Exact minimum: a negative signed operand with exp=0x43E (L) or exp=0x41E (W) and frac=0 gives 0x8000000000000000 or 0xFFFFFFFF80000000, with no flags.
- Priority of result selection:
  1. NaN or +Inf/+out-of-range: max value with NV. Max is 0x7FFFFFFFFFFFFFFF (signed L), 0x000000007FFFFFFF (signed W), or all-ones (unsigned L and W).
  2. −Inf or −out-of-range: signed gives min (0x8000000000000000, or 0xFFFFFFFF80000000 for W) with NV; unsigned gives 0 with NV.
  3. Unsigned, negative, |x|≥1: 0 with NV.
  4. |x|<1 (i_d2l_underflow or exp<0x3FF): 0.
  5. Otherwise: i_d2l_res. When w32, bits 63:32 are replaced by bit 31.

## Timing
- Reset values: o_res=0, o_fflags=0, o_valid=0, o_busy=0, state IDLE, all captured fields 0.
- Latency: o_valid rises on the clock edge after i_d2l_valid. That is 4 cycles after i_ena with the current 3-cycle converter.
- o_res and o_fflags are stable while o_valid=1.
- o_valid and i_ready both high → transfer happens and the block returns to IDLE on that edge. An i_ena in the same cycle is ignored.
- i_nrst low in any state → immediate return to reset values. A pending converter result is discarded.

## Configuration
- FCVT_D2I_NX_EN defined: NX is set when the result is in range (rule 4 or 5, or unsigned-negative |x|<1 that is nonzero) and the operand has a fractional part.
  - A fractional part means a nonzero value with exp<0x3FF, or any frac bit below position 0x433−exp being nonzero.
  - NX is never set together with NV.
- FCVT_D2I_NX_EN undefined: NX is always 0, and the fraction-mask logic is absent.

## Structure
- Package fcvt_d2i_post_pkg holds:
  - the state enum;
  - the saturation constants (max/min for L/W, signed/unsigned);
  - the exponent limits 0x3FF, 0x41D, 0x41E, 0x43D, 0x43E and 0x7FF;
  - the register struct typedef and its reset constant.
- Sub-module fcvt_d2i_classify is combinational. It takes the captured fields and outputs {nan, inf, zero, lt_one, out_of_range, exact_min, inexact}.

## Test plan
- 1.5 (0x3FF8000000000000), signed L, converter returns 1 → o_res=1; fflags=0x01 with the macro defined, 0x00 without; o_valid 1 cycle after i_d2l_valid.
- NaN 0x7FF8000000000000, signed W → o_res=0x000000007FFFFFFF, fflags=0x10.
- −2^63 (0xC3E0000000000000), signed L, converter flags overflow → o_res=0x8000000000000000, fflags=0x00.
- −3.0 (0xC008000000000000), unsigned L → o_res=0, fflags=0x10.
- −0.5 (0xBFE0000000000000), unsigned L → o_res=0, fflags=0x01 (macro defined).
- 2^32 (0x41F0000000000000), unsigned W, converter res 0 → o_res=0xFFFFFFFFFFFFFFFF, fflags=0x10.
- i_ready low for 5 cycles in DONE → o_res and o_valid held, o_busy=1, a second i_ena ignored.
- i_nrst pulse in WAIT → all outputs 0, state IDLE; a late i_d2l_valid is ignored.
